// File: rtl/axi4_sram_slave_if.sv
// AXI4 bundle between a master and the SRAM responder: write channels AW/W/B, read channels AR/R.
// Sideband cache/prot/qos fields are carried for completeness; the responder ignores them.
interface axi4_sram_slave_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  localparam int STRB_W = DATA_W / 8;

  logic [ID_W-1:0]   aw_id;
  logic [ADDR_W-1:0] aw_addr;
  logic [7:0]        aw_len;
  logic [2:0]        aw_size;
  logic [1:0]        aw_burst;
  logic [3:0]        aw_cache;
  logic [2:0]        aw_prot;
  logic [3:0]        aw_qos;
  logic              aw_valid;
  logic              aw_ready;

  logic [DATA_W-1:0] w_data;
  logic [STRB_W-1:0] w_strb;
  logic              w_last;
  logic              w_valid;
  logic              w_ready;

  logic [ID_W-1:0]   b_id;
  logic [1:0]        b_resp;
  logic              b_valid;
  logic              b_ready;

  logic [ID_W-1:0]   ar_id;
  logic [ADDR_W-1:0] ar_addr;
  logic [7:0]        ar_len;
  logic [2:0]        ar_size;
  logic [1:0]        ar_burst;
  logic [3:0]        ar_cache;
  logic [2:0]        ar_prot;
  logic [3:0]        ar_qos;
  logic              ar_valid;
  logic              ar_ready;

  logic [ID_W-1:0]   r_id;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_resp;
  logic              r_last;
  logic              r_valid;
  logic              r_ready;

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_cache, aw_prot, aw_qos, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_valid,
    output w_ready,
    output b_id, b_resp, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_cache, ar_prot, ar_qos, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_valid,
    input  r_ready
  );

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_cache, aw_prot, aw_qos, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_cache, ar_prot, ar_qos, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_valid,
    output r_ready
  );
endinterface

// File: rtl/axi4_sram_slave.sv
// AXI4 SRAM responder with independent read/write FSMs; first R beat 1 cycle after AR, B 1 cycle after last W.
// R outputs hold while r_ready=0 and the next word is prefetched on handshake, sustaining 1 beat/cycle.
module axi4_sram_slave #(
  parameter int                ID_W      = 4,
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 64,
  parameter int                MEM_WORDS = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000
) (
  input logic              clk,
  input logic              rst,
  axi4_sram_slave_if.slave axi
);
  localparam int                STRB_W     = DATA_W / 8;
  localparam int                OFF_W      = $clog2(STRB_W);
  localparam int                IDX_W      = $clog2(MEM_WORDS);
  localparam logic [ADDR_W-1:0] BEAT_BYTES = ADDR_W'(STRB_W);
  localparam logic [ADDR_W-1:0] DEPTH      = ADDR_W'(MEM_WORDS);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [1:0]        burst;
  } hdr_t;

  w_state_t          w_state, w_next;
  r_state_t          r_state, r_next;
  hdr_t              wh, rh;
  logic [7:0]        w_cnt, r_cnt;
  logic              w_err, r_err, rst_done;
  logic [DATA_W-1:0] r_dat;
  logic [DATA_W-1:0] mem [MEM_WORDS];

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  assign aw_hs = axi.aw_valid && axi.aw_ready;
  assign w_hs  = axi.w_valid  && axi.w_ready;
  assign b_hs  = axi.b_valid  && axi.b_ready;
  assign ar_hs = axi.ar_valid && axi.ar_ready;
  assign r_hs  = axi.r_valid  && axi.r_ready;

  logic unused;
  assign unused = ^{axi.aw_size, axi.aw_cache, axi.aw_prot, axi.aw_qos,
                    axi.ar_size, axi.ar_cache, axi.ar_prot, axi.ar_qos};

  // Readies stay low for one cycle after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_done <= 1'b0;
    else      rst_done <= 1'b1;
  end

  // Write address decode; the subtraction wraps, so addresses below BASE_ADDR need their own test.
  logic [ADDR_W-1:0] wr_off, wr_word;
  logic [IDX_W-1:0]  wr_idx;
  logic              wr_ok;
  assign wr_off  = wh.addr - BASE_ADDR;
  assign wr_word = wr_off >> OFF_W;
  assign wr_ok   = (wh.addr >= BASE_ADDR) && (wr_word < DEPTH);
  assign wr_idx  = wr_word[IDX_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) w_state <= W_IDLE;
    else      w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    unique case (w_state)
      W_IDLE:  if (aw_hs) w_next = W_DATA;
      W_DATA:  if (w_hs && (axi.w_last || w_cnt == wh.len)) w_next = W_RESP;
      W_RESP:  if (b_hs) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    axi.aw_ready = (w_state == W_IDLE) && rst_done;
    axi.w_ready  = (w_state == W_DATA);
    axi.b_valid  = (w_state == W_RESP);
    axi.b_id     = wh.id;
    axi.b_resp   = (w_state == W_RESP && w_err) ? 2'b10 : 2'b00;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wh    <= '0;
      w_cnt <= '0;
      w_err <= 1'b0;
    end else if (aw_hs) begin
      wh    <= {axi.aw_id, axi.aw_addr, axi.aw_len, axi.aw_burst};
      w_cnt <= '0;
      w_err <= 1'b0;
    end else if (w_hs) begin
      w_cnt <= w_cnt + 8'd1;
      if (wh.burst != 2'b00) wh.addr <= wh.addr + BEAT_BYTES;
      if (!wr_ok) w_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs && wr_ok) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (axi.w_strb[b]) mem[wr_idx][b*8 +: 8] <= axi.w_data[b*8 +: 8];
      end
    end
  end

  // Read side looks up the AR address in IDLE and the following beat's address in DATA.
  logic [ADDR_W-1:0] r_next_addr, rd_addr, rd_off, rd_word;
  logic [IDX_W-1:0]  rd_idx;
  logic              rd_ok, rd_load;
  assign r_next_addr = (rh.burst == 2'b00) ? rh.addr : rh.addr + BEAT_BYTES;
  assign rd_addr     = (r_state == R_IDLE) ? axi.ar_addr : r_next_addr;
  assign rd_off      = rd_addr - BASE_ADDR;
  assign rd_word     = rd_off >> OFF_W;
  assign rd_ok       = (rd_addr >= BASE_ADDR) && (rd_word < DEPTH);
  assign rd_idx      = rd_word[IDX_W-1:0];
  assign rd_load     = ar_hs || (r_hs && !axi.r_last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= R_IDLE;
    else      r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    unique case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_DATA;
      R_DATA:  if (r_hs && axi.r_last) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    axi.ar_ready = (r_state == R_IDLE) && rst_done;
    axi.r_valid  = (r_state == R_DATA);
    axi.r_id     = rh.id;
    axi.r_data   = r_dat;
    axi.r_resp   = (r_state == R_DATA && r_err) ? 2'b10 : 2'b00;
    axi.r_last   = (r_state == R_DATA) && (r_cnt == rh.len);
  end

  // r_dat samples the array before a same-edge write lands, so a colliding read sees old data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rh    <= '0;
      r_cnt <= '0;
      r_dat <= '0;
      r_err <= 1'b0;
    end else begin
      if (ar_hs) begin
        rh    <= {axi.ar_id, axi.ar_addr, axi.ar_len, axi.ar_burst};
        r_cnt <= '0;
      end else if (r_hs) begin
        rh.addr <= r_next_addr;
        r_cnt   <= r_cnt + 8'd1;
      end
      if (rd_load) begin
        r_dat <= rd_ok ? mem[rd_idx] : '0;
        r_err <= !rd_ok;
      end
    end
  end
endmodule
